regfile_multiport: RTL and testbench

//  Parametrised integer register file for the RV32I core: NRD combinational read ports, one write port.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_if.sv | 16 +
 rtl/regfile_read_port.sv | 20 ++
 rtl/regfile_multiport.sv | 54 +++++
 tb/tb_regfile_multiport.sv | 131 +++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, FSM encoding and width helper for the register file
package regfile_pkg;
  localparam int RF_XLEN = 32;
  localparam int RF_NREGS = 32;
  typedef enum logic {RF_CLEAR = 1'b0, RF_READY = 1'b1} rf_state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/regfile_if.sv
// regfile_if: decode/writeback-side bus of the register file
interface regfile_if #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int NRD = 2
);
  logic Flush;
  logic Write;
  logic [AW-1:0] Write_Reg;
  logic [XLEN-1:0] Write_Data;
  logic [NRD*AW-1:0] Read_Reg;
  logic [NRD*XLEN-1:0] Read_Data;
  logic Busy;
  modport master(output Flush, Write, Write_Reg, Write_Data, Read_Reg, input Read_Data, Busy);
  modport slave(input Flush, Write, Write_Reg, Write_Data, Read_Reg, output Read_Data, Busy);
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with clear, x0 and write-bypass selection
module regfile_read_port #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic            clearing,
  input  logic            wr_acc,
  input  logic [AW-1:0]   wr_addr,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [XLEN-1:0] arr_data,
  output logic [XLEN-1:0] rd_data
);
  always_comb
    rd_data = clearing ? '0 :
              (ZERO_REG != 0 && addr == '0) ? '0 :
              (BYPASS != 0 && wr_acc && wr_addr == addr) ? wr_data : arr_data;
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: NRD-read/1-write register file with hardwired x0, bypass and clear engine
module regfile_multiport import regfile_pkg::*; #(
  parameter int XLEN = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int AW = clog2(NREGS),
  parameter int NRD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic clock,
  input logic reset,
  regfile_if.slave bus
);
  rf_state_e state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic clearing, wr_acc, wr_en;
  logic [AW-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  always_comb begin
    clearing = state_q == RF_CLEAR;
    wr_acc = !clearing && !bus.Flush && !reset && bus.Write &&
             !(ZERO_REG != 0 && bus.Write_Reg == '0);
    wr_en = clearing || wr_acc;
    wr_addr = clearing ? clr_cnt_q : bus.Write_Reg;
    wr_data = clearing ? '0 : bus.Write_Data;
    state_d = bus.Flush ? RF_CLEAR :
              (clearing && clr_cnt_q == AW'(NREGS - 1)) ? RF_READY : state_q;
    clr_cnt_d = bus.Flush ? '0 : clearing ? clr_cnt_q + AW'(1) : clr_cnt_q;
  end
  // The clear engine shares the single write port; array entries need no reset of their own.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
    if (wr_en) regs_q[wr_addr] <= wr_data;
  end
  assign bus.Busy = clearing;
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    regfile_read_port #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd (
      .clearing(clearing),
      .wr_acc(wr_acc),
      .wr_addr(bus.Write_Reg),
      .addr(bus.Read_Reg[g*AW +: AW]),
      .wr_data(bus.Write_Data),
      .arr_data(regs_q[bus.Read_Reg[g*AW +: AW]]),
      .rd_data(bus.Read_Data[g*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed checks of clear engine, x0, bypass, flush and reset behaviour
module tb_regfile_multiport;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int n;
  always #5 clock = ~clock;
  regfile_if #(.XLEN(32), .AW(5), .NRD(2)) b0 ();
  regfile_if #(.XLEN(32), .AW(5), .NRD(2)) b1 ();
  assign b1.Flush = b0.Flush;
  assign b1.Write = b0.Write;
  assign b1.Write_Reg = b0.Write_Reg;
  assign b1.Write_Data = b0.Write_Data;
  assign b1.Read_Reg = b0.Read_Reg;
  regfile_multiport #(.NRD(2)) dut0 (.clock(clock), .reset(reset), .bus(b0));
  regfile_multiport #(.NRD(2), .BYPASS(0)) dut1 (.clock(clock), .reset(reset), .bus(b1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (b0.Busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    b0.Read_Reg = {a1, a0};
    #1;
  endtask
  initial begin
    b0.Flush = 1'b0;
    b0.Write = 1'b0;
    b0.Write_Reg = '0;
    b0.Write_Data = '0;
    b0.Read_Reg = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", b0.Busy, 1);
    reset = 1'b0;
    count_busy(n);
    check("rst_busy_len", n, 32);
    check("rst_busy_nb", b1.Busy, 0);
    for (int r = 0; r < 32; r++) begin
      rd(5'(r), 5'(31 - r));
      check("clr_p0", b0.Read_Data[31:0], 0);
      check("clr_p1", b0.Read_Data[63:32], 0);
    end
    b0.Write = 1'b1;
    b0.Write_Reg = 5'd5;
    b0.Write_Data = 32'hDEADBEEF;
    @(negedge clock);
    b0.Write = 1'b0;
    rd(5, 5);
    check("wr_p0", b0.Read_Data[31:0], 32'hDEADBEEF);
    check("wr_p1", b0.Read_Data[63:32], 32'hDEADBEEF);
    b0.Write = 1'b1;
    b0.Write_Reg = 5'd0;
    b0.Write_Data = 32'h12345678;
    rd(0, 0);
    check("x0_same_p0", b0.Read_Data[31:0], 0);
    check("x0_same_p1", b0.Read_Data[63:32], 0);
    @(negedge clock);
    b0.Write = 1'b0;
    #1;
    check("x0_after", b0.Read_Data[31:0], 0);
    b0.Write = 1'b1;
    b0.Write_Reg = 5'd7;
    b0.Write_Data = 32'hA5A5A5A5;
    rd(5, 7);
    check("byp_hit", b0.Read_Data[63:32], 32'hA5A5A5A5);
    check("nobyp_old", b1.Read_Data[63:32], 0);
    check("nobyp_p0", b1.Read_Data[31:0], 32'hDEADBEEF);
    @(negedge clock);
    b0.Write = 1'b0;
    #1;
    check("nobyp_next", b1.Read_Data[63:32], 32'hA5A5A5A5);
    check("byp_next", b0.Read_Data[63:32], 32'hA5A5A5A5);
    b0.Write = 1'b1;
    b0.Write_Reg = 5'd3;
    b0.Write_Data = 32'd1;
    @(negedge clock);
    b0.Flush = 1'b1;
    b0.Write_Reg = 5'd4;
    b0.Write_Data = 32'd2;
    rd(3, 4);
    check("fl_x3", b0.Read_Data[31:0], 1);
    check("fl_x4_nobyp", b0.Read_Data[63:32], 0);
    @(negedge clock);
    b0.Flush = 1'b0;
    b0.Write = 1'b0;
    rd(5, 5);
    check("fl_clear_rd", b0.Read_Data[31:0], 0);
    check("fl_busy", b0.Busy, 1);
    repeat (10) @(negedge clock);
    check("fl_busy10", b0.Busy, 1);
    b0.Flush = 1'b1;
    @(negedge clock);
    b0.Flush = 1'b0;
    count_busy(n);
    check("fl_busy_len", n, 32);
    rd(3, 4);
    check("fl_x3_zero", b0.Read_Data[31:0], 0);
    check("fl_x4_zero", b0.Read_Data[63:32], 0);
    b0.Flush = 1'b1;
    @(negedge clock);
    b0.Flush = 1'b0;
    b0.Write = 1'b1;
    b0.Write_Reg = 5'd9;
    b0.Write_Data = 32'hFF;
    rd(9, 9);
    check("busy_wr_rd", b0.Read_Data[31:0], 0);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_mid_busy", b0.Busy, 1);
    reset = 1'b0;
    count_busy(n);
    b0.Write = 1'b0;
    check("rst_mid_len", n, 32);
    rd(9, 9);
    check("x9_p0", b0.Read_Data[31:0], 0);
    check("x9_p1", b0.Read_Data[63:32], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
